// File: rtl/bcd_scan_controller.sv
// bcd_scan_controller: accepts a 4-digit BCD frame over a valid/ready handshake
// and scans it across a multiplexed display, DWELL cycles per digit.
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   load_valid  requester presents a frame on load_data
//   load_ready  controller can accept a frame this cycle
//   load_data   four BCD digits, digit0 in [3:0] .. digit3 in [15:12]
//   scan_en     1 = scan runs, 0 = scan frozen and display blanked
//   dig_sel     one-hot select of the digit currently driven
//   dec_out     one-hot decimal decode of the current digit (0 for codes 10..15)
//   frame_done  pulse on the last dwell cycle of digit3
//   bad_code    held frame contains at least one nibble above 9
module bcd_scan_controller #(
  parameter int unsigned DWELL = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [15:0] load_data,
  input  logic        scan_en,
  output logic [3:0]  dig_sel,
  output logic [9:0]  dec_out,
  output logic        frame_done,
  output logic        bad_code
);

  typedef enum logic {StIdle, StScan} state_e;

  localparam logic [7:0] CntMax = 8'(DWELL - 1);

  state_e      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] frame_q, frame_d;
  logic        bad_q, bad_d;

  logic        run;
  logic        frame_end;
  logic        xfer;
  logic [3:0]  nibble;

  always_comb begin
    run        = (state_q == StScan) && scan_en;
    frame_end  = run && (idx_q == 2'd3) && (cnt_q == CntMax);
    // Accepting only at frame end keeps a frame from being torn mid-scan.
    load_ready = (state_q == StIdle) || frame_end;
    xfer       = load_valid && load_ready;
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    frame_d = frame_q;
    bad_d   = bad_q;
    if (xfer) begin
      state_d = StScan;
      idx_d   = 2'd0;
      cnt_d   = 8'd0;
      frame_d = load_data;
      bad_d   = (load_data[3:0] > 4'd9) || (load_data[7:4] > 4'd9) ||
                (load_data[11:8] > 4'd9) || (load_data[15:12] > 4'd9);
    end else if (run) begin
      if (cnt_q == CntMax) begin
        cnt_d = 8'd0;
        idx_d = idx_q + 2'd1;  // wraps 3 -> 0, so frame end rescans the held frame
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= 2'd0;
      cnt_q   <= 8'd0;
      frame_q <= 16'd0;
      bad_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      frame_q <= frame_d;
      bad_q   <= bad_d;
    end
  end

  always_comb begin
    nibble     = frame_q[{idx_q, 2'b00} +: 4];
    dig_sel    = run ? (4'b0001 << idx_q) : 4'b0000;
    // Non-BCD codes blank the segment decode but keep the digit selected.
    dec_out    = (run && (nibble <= 4'd9)) ? (10'b00_0000_0001 << nibble) : 10'b0;
    frame_done = frame_end;
    bad_code   = bad_q;
  end

endmodule

// File: tb/tb_bcd_scan_controller.sv
// Scoreboard bench for bcd_scan_controller at DWELL=4: a behavioural model
// pushes expected outputs when stimulus is driven; they are popped and
// compared against the DUT at the falling edge. Directed checks ride along.
module tb_bcd_scan_controller;

  localparam int unsigned Dw = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_valid;
  logic        load_ready;
  logic [15:0] load_data;
  logic        scan_en;
  logic [3:0]  dig_sel;
  logic [9:0]  dec_out;
  logic        frame_done;
  logic        bad_code;

  typedef struct packed {
    logic [3:0] dig_sel;
    logic [9:0] dec_out;
    logic       frame_done;
    logic       load_ready;
    logic       bad_code;
  } obs_t;

  obs_t exp_q[$];

  int checks = 0;
  int errors = 0;

  // Model state
  logic        m_scan;
  int          m_idx;
  int          m_cnt;
  logic [15:0] m_frame;
  logic        m_bad;

  bcd_scan_controller #(.DWELL(Dw)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .scan_en    (scan_en),
    .dig_sel    (dig_sel),
    .dec_out    (dec_out),
    .frame_done (frame_done),
    .bad_code   (bad_code)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic obs_t model_out(input logic en);
    obs_t o;
    logic [3:0] nib;
    o = '0;
    o.bad_code   = m_bad;
    o.frame_done = m_scan && en && (m_idx == 3) && (m_cnt == Dw - 1);
    o.load_ready = !m_scan || o.frame_done;
    if (m_scan && en) begin
      nib       = 4'((m_frame >> (4 * m_idx)) & 16'hF);
      o.dig_sel = 4'(1 << m_idx);
      o.dec_out = (nib < 4'd10) ? 10'(1 << nib) : 10'd0;
    end
    return o;
  endfunction

  // One clock: drive inputs, score outputs at negedge, advance model at posedge.
  task automatic cycle(input logic r, input logic lv, input logic [15:0] d, input logic en,
                       output obs_t got);
    obs_t e;
    logic [15:0] dd;
    rst = r; load_valid = lv; load_data = d; scan_en = en;
    e = model_out(en);
    exp_q.push_back(e);
    @(negedge clk);
    got = '{dig_sel, dec_out, frame_done, load_ready, bad_code};
    e = exp_q.pop_front();
    check_eq("dig_sel", 32'(got.dig_sel), 32'(e.dig_sel));
    check_eq("dec_out", 32'(got.dec_out), 32'(e.dec_out));
    check_eq("frame_done", 32'(got.frame_done), 32'(e.frame_done));
    check_eq("load_ready", 32'(got.load_ready), 32'(e.load_ready));
    check_eq("bad_code", 32'(got.bad_code), 32'(e.bad_code));
    @(posedge clk);
    if (r) begin
      m_scan = 1'b0; m_idx = 0; m_cnt = 0; m_frame = '0; m_bad = 1'b0;
    end else if (lv && e.load_ready) begin
      dd = d;
      m_scan = 1'b1; m_idx = 0; m_cnt = 0; m_frame = dd;
      m_bad = (dd[3:0] > 9) || (dd[7:4] > 9) || (dd[11:8] > 9) || (dd[15:12] > 9);
    end else if (m_scan && en) begin
      if (m_cnt == Dw - 1) begin
        m_cnt = 0;
        m_idx = (m_idx + 1) % 4;
      end else begin
        m_cnt++;
      end
    end
    #1;
  endtask

  initial begin
    obs_t o;
    logic [9:0] dec_tbl [4];
    dec_tbl[0] = 10'h002; dec_tbl[1] = 10'h004; dec_tbl[2] = 10'h008; dec_tbl[3] = 10'h200;

    rst = 1'b1; load_valid = 1'b0; load_data = '0; scan_en = 1'b1;
    @(posedge clk); #1;
    m_scan = 1'b0; m_idx = 0; m_cnt = 0; m_frame = '0; m_bad = 1'b0;

    // Idle after reset
    cycle(1'b0, 1'b0, 16'h0, 1'b1, o);
    check_eq("idle_ready", 32'(o.load_ready), 32'd1);
    check_eq("idle_dig", 32'(o.dig_sel), 32'd0);

    // Load 9321 and scan one full frame, then rescan with 0005 pending
    cycle(1'b0, 1'b1, 16'h9321, 1'b1, o);
    for (int i = 1; i <= 16; i++) begin
      cycle(1'b0, 1'b0, 16'h0, 1'b1, o);
      check_eq("f1_dig", 32'(o.dig_sel), 32'(4'b0001 << ((i - 1) / 4)));
      check_eq("f1_dec", 32'(o.dec_out), 32'(dec_tbl[(i - 1) / 4]));
      check_eq("f1_done", 32'(o.frame_done), 32'(i == 16));
      check_eq("f1_ready", 32'(o.load_ready), 32'(i == 16));
    end
    for (int i = 1; i <= 16; i++) begin
      cycle(1'b0, 1'b1, 16'h0005, 1'b1, o);
      check_eq("f2_dec", 32'(o.dec_out), 32'(dec_tbl[(i - 1) / 4]));
      check_eq("f2_ready", 32'(o.load_ready), 32'(i == 16));
    end

    // First cycle of 0005 frame; then hold A0F7 until the next frame end
    cycle(1'b0, 1'b1, 16'hA0F7, 1'b1, o);
    check_eq("hand_dig", 32'(o.dig_sel), 32'h1);
    check_eq("hand_dec", 32'(o.dec_out), 32'h020);
    for (int i = 2; i <= 16; i++) begin
      cycle(1'b0, 1'b1, 16'hA0F7, 1'b1, o);
      check_eq("a_ready", 32'(o.load_ready), 32'(i == 16));
    end

    // Scan A0F7; present 1234 only on its frame end
    for (int k = 1; k <= 16; k++) begin
      cycle(1'b0, (k == 16), 16'h1234, 1'b1, o);
      check_eq("a_bad", 32'(o.bad_code), 32'd1);
      if (k == 1) check_eq("a_d0", 32'(o.dec_out), 32'h080);
      if (k == 5) begin
        check_eq("a_d1_dec", 32'(o.dec_out), 32'h000);
        check_eq("a_d1_sel", 32'(o.dig_sel), 32'h2);
      end
      if (k == 9) check_eq("a_d2", 32'(o.dec_out), 32'h001);
      if (k == 13) begin
        check_eq("a_d3_dec", 32'(o.dec_out), 32'h000);
        check_eq("a_d3_sel", 32'(o.dig_sel), 32'h8);
      end
    end

    // 1234 frame: run to idx=1, cnt=2, freeze for 5, resume
    for (int j = 1; j <= 6; j++) begin
      cycle(1'b0, 1'b0, 16'h0, 1'b1, o);
      check_eq("b_bad", 32'(o.bad_code), 32'd0);
    end
    for (int j = 0; j < 5; j++) begin
      cycle(1'b0, 1'b1, 16'h7777, 1'b0, o);
      check_eq("frz_out", 32'({o.dig_sel, o.dec_out, o.frame_done}), 32'd0);
      check_eq("frz_ready", 32'(o.load_ready), 32'd0);
    end
    for (int j = 0; j < 2; j++) begin
      cycle(1'b0, 1'b0, 16'h0, 1'b1, o);
      check_eq("res_sel", 32'(o.dig_sel), 32'h2);
      check_eq("res_dec", 32'(o.dec_out), 32'h008);
    end
    cycle(1'b0, 1'b0, 16'h0, 1'b1, o);
    check_eq("res_next", 32'(o.dig_sel), 32'h4);

    // Reset mid-scan with a bad-code frame presented on the reset edge
    cycle(1'b1, 1'b1, 16'hF000, 1'b1, o);
    for (int j = 0; j < 3; j++) begin
      cycle(1'b0, 1'b0, 16'h0, 1'b1, o);
      check_eq("rst_ready", 32'(o.load_ready), 32'd1);
      check_eq("rst_bad", 32'(o.bad_code), 32'd0);
      check_eq("rst_out", 32'({o.dig_sel, o.dec_out, o.frame_done}), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
